// File: rtl/imm_pkg.sv
// Shared immediate-format encodings for the decode/execute boundary.
// Format selects are 3-bit codes carried with each instruction word.
package imm_pkg;

    localparam int unsigned IMMSRC_W = 3;

    localparam logic [IMMSRC_W-1:0] IMM_I     = 3'b000;
    localparam logic [IMMSRC_W-1:0] IMM_S     = 3'b001;
    localparam logic [IMMSRC_W-1:0] IMM_B     = 3'b010;
    localparam logic [IMMSRC_W-1:0] IMM_J     = 3'b011;
    localparam logic [IMMSRC_W-1:0] IMM_U     = 3'b100;
    localparam logic [IMMSRC_W-1:0] IMM_SHAMT = 3'b101;
    localparam logic [IMMSRC_W-1:0] IMM_ZIMM  = 3'b110;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: instruction word + format select -> XLEN immediate.
// Unknown format selects produce zero with err raised.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]          inst,
    input  logic [IMMSRC_W-1:0]  immsrc,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [31:0] word;
    logic        sext;

    // Every format fits in 32 bits; only the final widening decides sign vs zero fill.
    always_comb begin
        word = '0;
        sext = 1'b1;
        err  = 1'b0;
        case (immsrc)
            IMM_I:     word = {{20{inst[31]}}, inst[31:20]};
            IMM_S:     word = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     word = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:     word = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:     word = {inst[31:12], 12'b0};
            IMM_SHAMT: begin
                sext = 1'b0;
                word = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
            end
            IMM_ZIMM:  begin
                sext = 1'b0;
                word = {27'b0, inst[19:15]};
            end
            default:   begin
                sext = 1'b0;
                err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (sext) imm = XLEN'($signed(word));
        else      imm = XLEN'(word);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with tag sideband, 2-entry skid buffer and flush.
// out_* is driven directly by the main register; the skid catches accepts while main is stalled.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [IMMSRC_W-1:0]  in_immsrc,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic             m_valid, s_valid, rdy_q;
    logic [XLEN-1:0]  m_imm, s_imm;
    logic [TAG_W-1:0] m_tag, s_tag;
    logic             m_err, s_err;

    logic             nx_m_valid, nx_s_valid, nx_rdy;
    logic [XLEN-1:0]  nx_m_imm, nx_s_imm;
    logic [TAG_W-1:0] nx_m_tag, nx_s_tag;
    logic             nx_m_err, nx_s_err;

    logic             accept, drain, main_free;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst   (in_inst),
        .immsrc (in_immsrc),
        .imm    (dec_imm),
        .err    (dec_err)
    );

    // Without the skid, readiness must look through to out_ready; rdy_q still masks the reset window.
    assign in_ready  = SKID_EN ? rdy_q : (rdy_q & (out_ready | ~m_valid));
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = m_valid & out_ready;
    assign main_free = ~m_valid | drain;

    always_comb begin
        nx_m_valid = m_valid;
        nx_m_imm   = m_imm;
        nx_m_tag   = m_tag;
        nx_m_err   = m_err;
        nx_s_valid = s_valid;
        nx_s_imm   = s_imm;
        nx_s_tag   = s_tag;
        nx_s_err   = s_err;
        if (flush) begin
            nx_m_valid = 1'b0;
            nx_s_valid = 1'b0;
        end else if (main_free) begin
            if (s_valid) begin
                nx_m_valid = 1'b1;
                nx_m_imm   = s_imm;
                nx_m_tag   = s_tag;
                nx_m_err   = s_err;
                nx_s_valid = accept;
                if (accept) begin
                    nx_s_imm = dec_imm;
                    nx_s_tag = in_tag;
                    nx_s_err = dec_err;
                end
            end else begin
                nx_m_valid = accept;
                if (accept) begin
                    nx_m_imm = dec_imm;
                    nx_m_tag = in_tag;
                    nx_m_err = dec_err;
                end
            end
        end else if (accept && SKID_EN) begin
            nx_s_valid = 1'b1;
            nx_s_imm   = dec_imm;
            nx_s_tag   = in_tag;
            nx_s_err   = dec_err;
        end
        nx_rdy = SKID_EN ? ~nx_s_valid : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_imm   <= '0;
            m_tag   <= '0;
            m_err   <= 1'b0;
            s_valid <= 1'b0;
            s_imm   <= '0;
            s_tag   <= '0;
            s_err   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            m_valid <= nx_m_valid;
            m_imm   <= nx_m_imm;
            m_tag   <= nx_m_tag;
            m_err   <= nx_m_err;
            s_valid <= nx_s_valid;
            s_imm   <= nx_s_imm;
            s_tag   <= nx_s_tag;
            s_err   <= nx_s_err;
            rdy_q   <= nx_rdy;
        end
    end

    assign out_valid = m_valid;
    assign out_imm   = m_imm;
    assign out_tag   = m_tag;
    assign out_err   = m_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and random-stream bench for imm_gen_pipe at XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_immsrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32, out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [31:0] tag;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input bit x64);
        logic [63:0] v;
        case (s)
            3'd0: v = {{52{i[31]}}, i[31:20]};
            3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
            3'd5: v = x64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
            3'd6: v = {59'b0, i[19:15]};
            default: v = '0;
        endcase
        return x64 ? v : {32'b0, v[31:0]};
    endfunction

    // One accepted transfer with out_ready high; returns 1 time unit after the capturing edge.
    task automatic apply(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_immsrc = src;
        in_tag    = tag;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input string nm, input logic [31:0] inst, input logic [2:0] src,
                       input logic [63:0] e32, input logic [63:0] e64, input logic e_err);
        apply(inst, src, inst ^ 32'h5a5a_0000);
        check_eq({nm, "_valid"}, {63'b0, out_valid32}, 64'd1);
        check_eq({nm, "_imm32"}, {32'b0, out_imm32}, e32);
        check_eq({nm, "_imm64"}, out_imm64, e64);
        check_eq({nm, "_err"},   {62'b0, out_err32, out_err64}, {62'b0, e_err, e_err});
        check_eq({nm, "_tag"},   {32'b0, out_tag32}, {32'b0, inst ^ 32'h5a5a_0000});
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] tag, input logic ordy);
        @(negedge clk);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_immsrc = 3'd0;
        in_tag    = tag;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            flush     = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        in_immsrc = '0; in_tag = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        check_eq("rst_in_ready",  {62'b0, in_ready32, in_ready64}, 64'd0);
        check_eq("rst_out_imm",   out_imm64 | {32'b0, out_imm32}, 64'd0);
        check_eq("rst_out_tag",   {32'b0, out_tag32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", {62'b0, in_ready32, in_ready64}, 64'd3);

        // Format vectors
        dir("i_neg1",  32'hFFF00093, 3'd0, 64'hFFFFFFFF,  64'hFFFFFFFFFFFFFFFF, 1'b0);
        dir("s_neg8",  32'hFE112C23, 3'd1, 64'hFFFFFFF8,  64'hFFFFFFFFFFFFFFF8, 1'b0);
        dir("b_neg4",  32'hFE000EE3, 3'd2, 64'hFFFFFFFC,  64'hFFFFFFFFFFFFFFFC, 1'b0);
        dir("j_800",   32'h0010006F, 3'd3, 64'h00000800,  64'h0000000000000800, 1'b0);
        dir("u_pos",   32'h123450B7, 3'd4, 64'h12345000,  64'h0000000012345000, 1'b0);
        dir("illegal", 32'hFFFFFFFF, 3'd7, 64'h0,         64'h0,                1'b1);
        dir("i_min",   32'h80000093, 3'd0, 64'hFFFFF800,  64'hFFFFFFFFFFFFF800, 1'b0);
        dir("shamt",   32'h03F01013, 3'd5, 64'h0000001F,  64'h000000000000003F, 1'b0);
        dir("u_neg",   32'h800000B7, 3'd4, 64'h80000000,  64'hFFFFFFFF80000000, 1'b0);
        dir("zimm",    32'h0007D073, 3'd6, 64'h0000000F,  64'h000000000000000F, 1'b0);
        @(posedge clk);
        #1;
        check_eq("drained_valid", {63'b0, out_valid32}, 64'd0);

        // Backpressure: two accepted, third held until release
        offer(32'h00100093, 32'hA1, 1'b0);
        check_eq("bp_a_tag",   {32'b0, out_tag32}, 64'hA1);
        check_eq("bp_a_ready", {63'b0, in_ready32}, 64'd1);
        offer(32'h00200093, 32'hB2, 1'b0);
        check_eq("bp_b_full",  {63'b0, in_ready32}, 64'd0);
        check_eq("bp_b_hold",  {32'b0, out_tag32}, 64'hA1);
        offer(32'hFFD00093, 32'hC3, 1'b0);
        check_eq("bp_c_hold",  {32'b0, out_tag32}, 64'hA1);
        check_eq("bp_c_imm",   {32'b0, out_imm32}, 64'h1);
        check_eq("bp_c_ready", {63'b0, in_ready32}, 64'd0);
        offer(32'hFFD00093, 32'hC3, 1'b1);
        check_eq("bp_out_b_tag", {32'b0, out_tag32}, 64'hB2);
        check_eq("bp_out_b_imm", {32'b0, out_imm32}, 64'h2);
        check_eq("bp_rdy_again", {63'b0, in_ready32}, 64'd1);
        offer(32'hFFD00093, 32'hC3, 1'b1);
        check_eq("bp_out_c_tag", {32'b0, out_tag32}, 64'hC3);
        check_eq("bp_out_c_imm", out_imm64, 64'hFFFFFFFFFFFFFFFD);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bp_empty", {63'b0, out_valid32}, 64'd0);

        // Flush with both entries full and an input offered
        offer(32'h00100093, 32'hD1, 1'b0);
        offer(32'h00200093, 32'hD2, 1'b0);
        @(negedge clk);
        in_inst = 32'h00300093; in_tag = 32'hD3; flush = 1'b1;
        @(posedge clk);
        #1;
        check_eq("fl_valid", {63'b0, out_valid32}, 64'd0);
        check_eq("fl_ready", {63'b0, in_ready32}, 64'd1);
        idle_cycles(1);
        @(posedge clk);
        #1;
        check_eq("fl_no_ghost", {63'b0, out_valid32}, 64'd0);

        // Flush while in_ready=1: offered input still dropped
        offer(32'h00400093, 32'hE1, 1'b0);
        @(negedge clk);
        in_inst = 32'h00500093; in_tag = 32'hE2; flush = 1'b1;
        @(posedge clk);
        #1;
        check_eq("fl2_valid", {63'b0, out_valid32}, 64'd0);
        idle_cycles(2);
        @(posedge clk);
        #1;
        check_eq("fl2_no_ghost", {63'b0, out_valid32}, 64'd0);

        // Async reset between edges
        offer(32'h00600093, 32'hF1, 1'b0);
        offer(32'h00700093, 32'hF2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
        check_eq("arst_ready", {63'b0, in_ready32}, 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_ready_after", {63'b0, in_ready32}, 64'd1);
        check_eq("arst_no_survivor", {63'b0, out_valid32}, 64'd0);

        // Random stream against scoreboard
        begin
            logic [31:0] tag_ctr;
            exp_t e;
            tag_ctr = 32'h1000;
            for (int n = 0; n < 320; n++) begin
                @(negedge clk);
                if (n < 300) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    in_inst   = $urandom;
                    in_immsrc = 3'($urandom_range(0, 6));
                    in_tag    = tag_ctr;
                end else begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end
                #1;
                if (out_valid32 && out_ready) begin
                    if (q.size() == 0) begin
                        check_eq("rnd_spurious", {32'b0, out_tag32}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check_eq("rnd_tag",   {32'b0, out_tag32}, {32'b0, e.tag});
                        check_eq("rnd_imm32", {32'b0, out_imm32}, e.i32);
                        check_eq("rnd_imm64", out_imm64, e.i64);
                    end
                end
                if (in_valid && in_ready32) begin
                    e.i32 = ref_imm(in_inst, in_immsrc, 1'b0);
                    e.i64 = ref_imm(in_inst, in_immsrc, 1'b1);
                    e.tag = in_tag;
                    q.push_back(e);
                    tag_ctr++;
                end
            end
            check_eq("rnd_left", 64'(q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
